// File: rtl/fifo_loop_checker.sv
// FIFO loopback exerciser: writes an XOR-patterned burst into an internal FIFO,
// waits, reads it back and counts mismatches for status LEDs / ILA.
module fifo_loop_checker #(
  parameter int unsigned DATA_W       = 4,
  parameter int unsigned DEPTH_LOG2   = 4,
  parameter int unsigned BURST_LEN    = 16,
  parameter int unsigned GAP_CYCLES   = 6,
  parameter logic [31:0] PATTERN_SEED = 32'h0000_0009
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              start,
  input  logic              err_inject,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_cnt,
  output logic              ovf,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              wr_en_mon,
  output logic              rd_en_mon,
  output logic [DATA_W-1:0] last_bad
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam int unsigned KW    = DEPTH_LOG2 + 2;
  localparam int unsigned E_LEN = (BURST_LEN < DEPTH) ? BURST_LEN : DEPTH;

  localparam logic [DATA_W-1:0] SEED_W  = DATA_W'(PATTERN_SEED);
  localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
  localparam logic [KW-1:0]     B_LAST  = KW'(BURST_LEN - 1);
  localparam logic [KW-1:0]     E_K     = KW'(E_LEN);
  localparam logic [KW-1:0]     E_LAST  = KW'(E_LEN - 1);
  localparam logic [7:0]        G_LAST  = 8'(GAP_CYCLES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  function automatic logic [DATA_W-1:0] pattern_word(input logic [KW-1:0] idx);
    return DATA_W'(idx) ^ SEED_W;
  endfunction

  // FIFO storage and flags
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wptr_q, rptr_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              full_q, empty_q;
  logic [DATA_W-1:0] dout_q, din;
  logic              wr_acc, rd_acc;

  // Sequencer
  logic [2:0]        state_q, state_d;
  logic              start_q, armed_q, rise;
  logic [KW-1:0]     k_q, k_d, rcnt_q, rcnt_d, cmp_idx_q, cmp_idx_d, chk_q, chk_d;
  logic [7:0]        gap_q, gap_d;
  logic              wr_en_q, wr_en_d, rd_en_q, rd_en_d, cmp_vld_q, cmp_vld_d;
  logic [15:0]       err_q, err_d;
  logic              ovf_q, ovf_d, busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [DATA_W-1:0] lb_q, lb_d;

  assign wr_acc = wr_en_q & ~full_q;
  assign rd_acc = rd_en_q & ~empty_q;
  assign din    = pattern_word(k_q) ^ DATA_W'(err_inject && (k_q == '0));

  always_comb begin
    cnt_d = cnt_q;
    if (wr_acc && !rd_acc) begin
      cnt_d = cnt_q + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wptr_q] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      dout_q  <= '0;
    end else begin
      if (wr_acc) wptr_q <= wptr_q + PW'(1);
      if (rd_acc) begin
        rptr_q <= rptr_q + PW'(1);
        dout_q <= mem[rptr_q];
      end
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == DEPTH_C);
      empty_q <= (cnt_d == '0);
    end
  end

  // armed blocks a start that was already high when reset was applied
  assign rise = start & ~start_q & armed_q;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    gap_d     = gap_q;
    rcnt_d    = rcnt_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    cmp_vld_d = 1'b0;
    cmp_idx_d = cmp_idx_q;
    err_d     = err_q;
    chk_d     = chk_q;
    ovf_d     = ovf_q;
    lb_d      = lb_q;

    if (cmp_vld_q) begin
      chk_d = chk_q + KW'(1);
      if (dout_q != pattern_word(cmp_idx_q)) begin
        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
        lb_d = dout_q;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (rise) begin
          state_d = S_WRITE;
          k_d     = '0;
          err_d   = '0;
          chk_d   = '0;
          ovf_d   = 1'b0;
          lb_d    = '0;
          wr_en_d = 1'b1;
        end
      end
      S_WRITE: begin
        k_d = k_q + KW'(1);
        if (wr_en_q && full_q) ovf_d = 1'b1;
        if (k_q == B_LAST) begin
          if (GAP_CYCLES == 0) begin
            state_d = S_READ;
            rd_en_d = 1'b1;
            rcnt_d  = '0;
          end else begin
            state_d = S_GAP;
            gap_d   = '0;
          end
        end else begin
          wr_en_d = 1'b1;
        end
      end
      S_GAP: begin
        gap_d = gap_q + 8'd1;
        if (gap_q == G_LAST) begin
          state_d = S_READ;
          rd_en_d = 1'b1;
          rcnt_d  = '0;
        end
      end
      S_READ: begin
        // the cycle after the last read only waits for its compare
        if (rd_en_q) begin
          rcnt_d    = rcnt_q + KW'(1);
          cmp_vld_d = ~empty_q;
          cmp_idx_d = rcnt_q;
          rd_en_d   = (rcnt_q != E_LAST);
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_WRITE) || (state_d == S_GAP) || (state_d == S_READ);
    done_d = (state_d == S_DONE);
    pass_d = (state_d == S_DONE) && (err_d == '0) && (chk_d == E_K);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q   <= S_IDLE;
      start_q   <= 1'b0;
      armed_q   <= ~start;
      k_q       <= '0;
      gap_q     <= '0;
      rcnt_q    <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      cmp_vld_q <= 1'b0;
      cmp_idx_q <= '0;
      err_q     <= '0;
      chk_q     <= '0;
      ovf_q     <= 1'b0;
      lb_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start;
      if (!start) armed_q <= 1'b1;
      k_q       <= k_d;
      gap_q     <= gap_d;
      rcnt_q    <= rcnt_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      cmp_vld_q <= cmp_vld_d;
      cmp_idx_q <= cmp_idx_d;
      err_q     <= err_d;
      chk_q     <= chk_d;
      ovf_q     <= ovf_d;
      lb_q      <= lb_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign ovf        = ovf_q;
  assign fifo_full  = full_q;
  assign fifo_empty = empty_q;
  assign wr_en_mon  = wr_en_q;
  assign rd_en_mon  = rd_en_q;
  assign last_bad   = lb_q;

endmodule

// File: doc/fifo_loop_checker.md
Name: fifo_loop_checker

Overview:
Parametrised, self-checking FIFO loopback exerciser. It contains a generic synchronous FIFO of configurable width and depth, and a sequencer driven by a trigger. On each trigger the sequencer writes a burst of patterned words, waits, reads the words back and compares them against the expected values. It reports busy, done, pass, an error count and an overflow flag for board status LEDs and ILA debug.

Parameters:
DATA_W, 4, FIFO word width in bits (2..32).
DEPTH_LOG2, 4, FIFO depth is 2**DEPTH_LOG2 words.
BURST_LEN, 16, words written per run (1..2**(DEPTH_LOG2+1)); may exceed the depth to exercise the full condition.
GAP_CYCLES, 6, idle cycles between the last write and the first read (0..255).
PATTERN_SEED, 4'b1001 zero-extended/truncated to DATA_W, XOR seed; word k = k[DATA_W-1:0] ^ PATTERN_SEED.

Ports:
clk  in  1  single clock domain; all logic on rising edge
srst  in  1  synchronous active-high reset
start  in  1  level trigger (switch); rising edge detected internally
err_inject  in  1  when high during the first write cycle of a run, word 0 is written with its LSB inverted
busy  out  1  high from the first write cycle through the last compare
done  out  1  high in DONE until the next accepted start or srst
pass  out  1  valid when done=1: err_cnt==0 and checked==expected count
err_cnt  out  16  mismatches in the current run, saturating at 16'hFFFF
ovf  out  1  sticky per run: a write was attempted while the FIFO was full
fifo_full  out  1  FIFO full flag
fifo_empty  out  1  FIFO empty flag
wr_en_mon  out  1  copy of the internal wr_en (LED/ILA)
rd_en_mon  out  1  copy of the internal rd_en (LED/ILA)
last_bad  out  DATA_W  dout value of the most recent mismatch

Behaviour:
- Reset (srst=1 at a clk edge, any state, including mid-run):
  - FIFO: pointers=0, count=0, dout=0.
  - Sequencer: state IDLE.
  - Outputs: busy=0, done=0, pass=0, err_cnt=0, ovf=0, last_bad=0, wr_en/rd_en=0.
  - start_q=0; a start held high through reset does not trigger a run until it goes low then high.
- FIFO:
  - count spans 0..DEPTH; full = (count==DEPTH); empty = (count==0). Both flags are registered-consistent with count.
  - A write is accepted iff wr_en & !full. A read is accepted iff rd_en & !empty. Simultaneous accepted read and write leave count unchanged.
  - Pointers wrap modulo DEPTH.
  - Standard (non-FWFT) read: dout updates on the clk edge after an accepted read and holds otherwise.
- Trigger: start_q <= start; rise = start & !start_q. A rise is accepted only in IDLE or DONE. Rises in any other state are ignored.
- States:
  - IDLE/DONE -> WRITE on an accepted rise. This clears err_cnt, ovf, pass, done, last_bad, and the word index k=0.
  - WRITE: wr_en=1 for exactly BURST_LEN consecutive cycles with din = word k, k incrementing every cycle. If full, the write is dropped, ovf <= 1, and k still increments. -> GAP.
  - GAP: no enables for GAP_CYCLES cycles; GAP_CYCLES=0 goes straight to READ. -> READ.
  - READ: rd_en=1 for E = min(BURST_LEN, DEPTH) consecutive cycles. The compare occurs one cycle after each accepted read: dout vs word j, j=0..E-1. On mismatch: err_cnt+1 (saturating) and last_bad <= dout. checked+1 per compare. -> DONE after the final compare (E+1 cycles after READ entry).
  - DONE: done=1, pass = (err_cnt==0) & (checked==E). The FIFO is empty.
- Pattern arithmetic: k and j are counters of width DEPTH_LOG2+2. The pattern uses only the low DATA_W bits (wrap-around intended).
- busy = (state ∈ {WRITE, GAP, READ}).

Test Plan:
1. Defaults, start 0->1 once -> 16 wr_en cycles with din 9,8,B,A,D,C,F,E,1,0,3,2,5,4,7,6; fifo_full=1 after the 16th write; 6 idle cycles; 16 reads return the same sequence; done=1, pass=1, err_cnt=0, ovf=0.
2. err_inject=1 on the first write cycle -> word 0 is written as 4'h8; done=1, pass=0, err_cnt=1, last_bad=4'h8.
3. BURST_LEN=20, DEPTH_LOG2=4 -> writes 17..20 are dropped, ovf=1; 16 reads return words 0..15; pass=1.
4. Assert srst mid-READ (after 5 reads) -> next cycle all outputs are 0 and fifo_empty=1; start held high does not retrigger; start low->high re-runs and passes.
5. Pulse start again during WRITE and during GAP -> no restart; the run completes normally; a second start from DONE clears err_cnt/done and re-runs.
6. DATA_W=8, DEPTH_LOG2=2, BURST_LEN=3, GAP_CYCLES=0 -> writes 0x09,0x08,0x0B; READ begins the cycle after the last write; pass=1 with fifo_full never asserted.
